pipe_stage_skid: RTL and testbench

- Generic, parametrised inter-stage pipeline register: the successor to the fixed-field ID/EX-style latches.
- Carries a control bundle and a data bundle under a valid/ready handshake, with a 2-entry skid buffer so back-pressure never forms a combinational ready path.
- Supports squash (flush) and guarantees zeroed control on bubbles.
- Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-stage widths.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_stage_entry.sv | 26 ++
 rtl/pipe_stage_skid.sv | 164 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register constants: occupancy encodings and per-stage bundle widths.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int IF_ID_CTRL_W  = 2;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 11;
  localparam int ID_EX_DATA_W  = 103;
  localparam int EX_MEM_CTRL_W = 6;
  localparam int EX_MEM_DATA_W = 101;
  localparam int MEM_WB_CTRL_W = 3;
  localparam int MEM_WB_DATA_W = 69;

  // Upstream may push in the next cycle unless that cycle holds both entries.
  function automatic logic occ_accepts(input logic [1:0] occ);
    return occ != OCC_FULL;
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One control+data holding register; reset/clear zero it, load captures a new beat.
module pipe_stage_entry #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 103
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ctrl <= '0;
      data <= '0;
    end else if (load) begin
      ctrl <= ctrl_in;
      data <= data_in;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Skid pipeline register: 1-cycle latency, registered in_ready, 2 entries absorb a stall.
// Optional stall/flush counters when PIPE_STAGE_SKID_STATS_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
`ifdef PIPE_STAGE_SKID_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
`ifdef PIPE_STAGE_SKID_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
`endif
  output logic [1:0]        occupancy_o
);

  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic              in_ready_q;
  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_drain;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] main_ctrl_nxt;
  logic [DATA_W-1:0] main_data_nxt;

  assign out_valid_o = (occ_q != OCC_EMPTY);
  assign in_fire     = in_valid_i & in_ready_q;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    occ_d          = occ_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drain     = 1'b0;
    if (flush_i) begin
      // Entries are zeroed through the clear inputs; the incoming beat is dropped.
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            occ_d     = OCC_BUSY;
            main_load = 1'b1;
          end
        end
        OCC_BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            occ_d     = OCC_FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            occ_d          = OCC_BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_drain     = 1'b1;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_ctrl_nxt = in_ctrl_i;
    main_data_nxt = in_data_i;
    if (main_from_skid) begin
      main_ctrl_nxt = skid_ctrl;
      main_data_nxt = skid_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= occ_accepts(occ_d);
    end
  end

  pipe_stage_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (flush_i),
    .load    (main_load),
    .ctrl_in (main_ctrl_nxt),
    .data_in (main_data_nxt),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

  pipe_stage_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (flush_i | skid_drain),
    .load    (skid_load),
    .ctrl_in (in_ctrl_i),
    .data_in (in_data_i),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

  // Bubbles must never carry write-enable bits downstream.
  assign out_ctrl_o  = out_valid_o ? main_ctrl : '0;
  assign out_data_o  = main_data;
  assign in_ready_o  = in_ready_q;
  assign occupancy_o = occ_q;

`ifdef PIPE_STAGE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_i && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + random bench for pipe_stage_skid against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int CW = 11;
  localparam int DW = 103;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_SKID_STATS_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   flush_cnt;
  logic          sat_in_ready;
  logic          sat_out_valid;
  logic [CW-1:0] sat_out_ctrl;
  logic [DW-1:0] sat_out_data;
  logic [1:0]    sat_stall_cnt;
  logic [1:0]    sat_flush_cnt;
  logic [1:0]    sat_occupancy;
`endif

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (out_ctrl),
    .out_data_o  (out_data),
`ifdef PIPE_STAGE_SKID_STATS_EN
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt),
`endif
    .occupancy_o (occupancy)
  );

`ifdef PIPE_STAGE_SKID_STATS_EN
  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(2)) dut_sat (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (sat_in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_data_i   (in_data),
    .out_valid_o (sat_out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (sat_out_ctrl),
    .out_data_o  (sat_out_data),
    .stall_cnt_o (sat_stall_cnt),
    .flush_cnt_o (sat_flush_cnt),
    .occupancy_o (sat_occupancy)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         mq[$];
  logic [DW-1:0] m_last_d;
  int            n_cmp;
  int            n_bad;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the stage is a FIFO of depth 2; reset/flush empty it and zero the held data.
  task automatic model_step();
    logic ifire;
    logic ofire;
    beat_t b;
    if (rst || flush) begin
      mq.delete();
      m_last_d = '0;
    end else begin
      ifire = in_valid && (mq.size() < 2);
      ofire = (mq.size() > 0) && out_ready;
      if (ofire) begin
        m_last_d = mq[0].d;
        void'(mq.pop_front());
      end
      if (ifire) begin
        b.c = in_ctrl;
        b.d = in_data;
        mq.push_back(b);
      end
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(mq.size() < 2));
    chk("occupancy", 128'(occupancy), 128'(mq.size()));
    chk("out_ctrl", 128'(out_ctrl), (mq.size() > 0) ? 128'(mq[0].c) : 128'd0);
    chk("out_data", 128'(out_data), (mq.size() > 0) ? 128'(mq[0].d) : 128'(m_last_d));
  endtask

  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic r);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [DW-1:0] seq_data(input int n);
    return DW'(n) | (DW'(n) << 64);
  endfunction

  function automatic logic [CW-1:0] seq_ctrl(input int n);
    return CW'(n) ^ 11'h2A5;
  endfunction

  initial begin
    int sent;
    int recv;
    int cyc;
    logic v;
    logic r;
    clk = 0; n_cmp = 0; n_bad = 0; m_last_d = '0;
    in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0; flush = 0; rst = 1;

    // Reset state
    cycle(0, '0, '0, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 1);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_ready", 128'(in_ready), 128'd1);
    chk("rst_data", 128'(out_data), 128'd0);

    // 1: single beat, one-cycle latency
    cycle(1, 11'h7FF, 103'h1234, 1, 0, 0);
    chk("t1_valid", 128'(out_valid), 128'd1);
    chk("t1_ctrl", 128'(out_ctrl), 128'h7FF);
    chk("t1_data", 128'(out_data), 128'h1234);
    chk("t1_occ", 128'(occupancy), 128'd1);
    cycle(0, '0, '0, 1, 0, 0);
    chk("t1_drain_ctrl", 128'(out_ctrl), 128'd0);
    chk("t1_hold_data", 128'(out_data), 128'h1234);

    // 2: fill under stall, then release in order
    cycle(0, '0, '0, 0, 0, 1);
    cycle(1, 11'h011, 103'h11, 0, 0, 0);
    cycle(1, 11'h022, 103'h22, 0, 0, 0);
    chk("t2_occ_full", 128'(occupancy), 128'd2);
    chk("t2_ready_low", 128'(in_ready), 128'd0);
    cycle(0, '0, '0, 0, 0, 0);
    chk("t2_stall_hold", 128'(out_data), 128'h11);
    cycle(0, '0, '0, 1, 0, 0);
    chk("t2_b_next", 128'(out_data), 128'h22);
    chk("t2_ready_back", 128'(in_ready), 128'd1);
    cycle(0, '0, '0, 1, 0, 0);
    chk("t2_empty", 128'(occupancy), 128'd0);

    // 3: flush while FULL drops the incoming beat
    cycle(1, 11'h011, 103'h11, 0, 0, 0);
    cycle(1, 11'h022, 103'h22, 0, 0, 0);
    cycle(1, 11'h033, 103'h33, 0, 1, 0);
    chk("t3_valid", 128'(out_valid), 128'd0);
    chk("t3_ctrl", 128'(out_ctrl), 128'd0);
    chk("t3_occ", 128'(occupancy), 128'd0);
    chk("t3_data", 128'(out_data), 128'd0);
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    chk("t3_no_c", 128'(out_valid), 128'd0);

    // 5: reset while FULL and stalled
    cycle(1, 11'h044, 103'h44, 0, 0, 0);
    cycle(1, 11'h055, 103'h55, 0, 0, 0);
    cycle(1, 11'h066, 103'h66, 0, 0, 1);
    chk("t5_valid", 128'(out_valid), 128'd0);
    chk("t5_occ", 128'(occupancy), 128'd0);
    chk("t5_ready", 128'(in_ready), 128'd1);
    chk("t5_data", 128'(out_data), 128'd0);

`ifdef PIPE_STAGE_SKID_STATS_EN
    // 6: counters, plus a 2-bit instance that must saturate
    cycle(1, 11'h077, 103'h77, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, '0, 0, 0, 0);
    cycle(0, '0, '0, 1, 1, 0);
    cycle(0, '0, '0, 1, 1, 0);
    chk("t6_stall", 128'(stall_cnt), 128'd5);
    chk("t6_flush", 128'(flush_cnt), 128'd2);
    cycle(1, 11'h088, 103'h88, 0, 0, 0);
    cycle(0, '0, '0, 0, 0, 0);
    chk("t6_stall6", 128'(stall_cnt), 128'd6);
    chk("t6_sat", 128'(sat_stall_cnt), 128'd3);
    cycle(0, '0, '0, 1, 0, 1);
    chk("t6_rst_clr", 128'(stall_cnt), 128'd0);
`endif

    // 4: random valid/ready, incrementing payload, strict in-order delivery
    cycle(0, '0, '0, 0, 0, 1);
    sent = 0; recv = 0; cyc = 0;
    while (recv < 10000 && cyc < 60000) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      if (out_valid && r) begin
        chk("seq_data", 128'(out_data), 128'(seq_data(recv)));
        chk("seq_ctrl", 128'(out_ctrl), 128'(seq_ctrl(recv)));
        recv++;
      end
      if (v && mq.size() < 2) begin
        cycle(1, seq_ctrl(sent), seq_data(sent), r, 0, 0);
        sent++;
      end else begin
        cycle(v, seq_ctrl(sent), seq_data(sent), r, 0, 0);
      end
      cyc++;
    end
    chk("seq_done", 128'(recv), 128'd10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
